// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multiplexed hexadecimal seven-segment driver.
package hex_disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int unsigned VALUE_W    = 4 * NUM_DIGITS;
  localparam int unsigned DATA_W     = VALUE_W + 1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Index of the most significant nonzero nibble; 0 for an all-zero value
  function automatic logic [DIGIT_W-1:0] lead_digit(input logic [VALUE_W-1:0] v);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (v[4*k +: 4] != 4'h0) idx = DIGIT_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to active-low seven-segment {g..a} decoder.
module hex7seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] code_c_o
);

  assign code_c_o = HEX_SEG[nib_i];

endmodule

// File: rtl/hex_scan_display.sv
// Eight-digit scanned hex display driver with frame-aligned input latching and per-slot blanking.
// Build option: HEX_SCAN_LEAD_ZERO_BLANK_EN enables leading-zero suppression.
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic [DATA_W-1:0]   data,
  output logic [DIGIT_W-1:0]  which,
  output logic [7:0]          seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]      pcnt_q,  pcnt_d;
  logic [DIGIT_W-1:0] which_q, which_d;
  logic [DATA_W-1:0]  shd_q,   shd_d;
  logic [7:0]         seg_q,   seg_d;

  logic               tick_c;
  logic               frame_end_c;
  logic [VALUE_W-1:0] val_c;
  logic [3:0]         nib_c;
  logic [6:0]         code_c;
  logic               digit_on_c;

  hex7seg_decoder u_dec (
    .nib_i    (nib_c),
    .code_c_o (code_c)
  );

  // Output is computed from next-state values so seg and which leave the flops together
  always_comb begin
    tick_c      = (pcnt_q == PW'(SCAN_DIV - 1));
    frame_end_c = tick_c && (which_q == DIGIT_W'(NUM_DIGITS - 1));
    pcnt_d      = tick_c ? '0 : pcnt_q + PW'(1);
    which_d     = tick_c ? which_q + DIGIT_W'(1) : which_q;
    shd_d       = frame_end_c ? data : shd_q;
    val_c       = shd_d[DATA_W-1:1];
    nib_c       = val_c[{which_d, 2'b00} +: 4];
`ifdef HEX_SCAN_LEAD_ZERO_BLANK_EN
    digit_on_c  = (which_d <= lead_digit(val_c));
`else
    digit_on_c  = 1'b1;
`endif
    seg_d       = {1'b1, code_c};
    if (32'(pcnt_d) < BLANK_CYC) begin
      seg_d = SEG_BLANK;
    end else if (!shd_d[0]) begin
      seg_d = SEG_DASH;
    end else if (!digit_on_c) begin
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      pcnt_q  <= '0;
      which_q <= '0;
      shd_q   <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      pcnt_q  <= pcnt_d;
      which_q <= which_d;
      shd_q   <= shd_d;
      seg_q   <= seg_d;
    end
  end

  assign which = which_q;
  assign seg   = seg_q;

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Time-multiplexed 8-digit hexadecimal driver for the board's seven-segment display.
- Sits directly downstream of the board-level test harness and consumes its 33-bit `data` word: a 32-bit value plus a valid flag.
- Scans one digit at a time, latches the input only at frame boundaries so a frame never mixes two values, and inserts a short blanking gap at each digit change to suppress ghosting.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be ≥ 2.
- BLANK_CYC, 16: cycles at the start of each slot with all segments off; 0 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock; one clock domain; reset is synchronous and active-high.
- Rst  in  1  synchronous active-high reset.
- data  in  33  bits [32:1] = value; bit [0] = valid flag.
- which  out  3  digit select, 0 = least-significant nibble (rightmost digit).
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; 0 = lit.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when `pcnt == SCAN_DIV-1`.
- On `tick`, `which` advances modulo 8, so 7 wraps to 0.
- Shadow register `shd[32:0]` loads `data` on the cycle where `tick` is high and `which == 7` (the frame boundary).
  - `data` is ignored at all other times.
- Digit k displays nibble `shd[4k+4:4k+1]` through the hex decoder:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- If `shd[0] == 0` (invalid), every digit shows dash 8'hBF.
- dp is always off (seg[7] = 1).
- Blanking: while `pcnt < BLANK_CYC`, seg = 8'hFF regardless of content.
- Frame length is 8·SCAN_DIV cycles.

## Timing
- `which` and `seg` are registered and updated together.
  - `seg` always corresponds to the digit currently selected by `which`; they are never skewed by a cycle.
- A `data` change becomes visible on digit 0 at the first slot after the next frame boundary.
  - Worst-case latency is 8·SCAN_DIV + 1 cycles.
- Reset (checked before every other condition), effective the cycle after `Rst` is sampled high, including mid-frame:
  - pcnt=0, which=0, shd=0 (invalid), seg=8'hFF.
- First cycle after `Rst` deasserts: BLANK_CYC cycles of FF, then dashes (8'hBF) until the first frame boundary.
- Simultaneous events:
  - `Rst` wins over `tick` and over the shadow load.
  - Shadow load and the which 7→0 step occur on the same edge.
  - The new value is decoded from the first cycle of slot 0.
- BLANK_CYC = 0: no blanking cycles.

## Configuration
- `HEX_SCAN_LEAD_ZERO_BLANK_EN` defined: leading-zero suppression.
  - Digits above the highest nonzero nibble of `shd` show 8'hFF.
  - Digit 0 is always shown, so value 0 displays a single "0".
  - Suppression applies only when valid; invalid still shows dashes on all digits.
- Undefined: all 8 digits are always displayed, including leading zeros.

## Structure
- Package `hex_disp_pkg`:
  - constants NUM_DIGITS=8, SEG_BLANK=8'hFF, SEG_DASH=8'hBF;
  - the 16-entry segment code constants.
- Sub-module `hex7seg_decoder`: combinational 4-bit nibble → 7-bit {g..a} active-low code. Instantiated once and fed by a nibble mux on `which`.
- Top module holds prescaler, digit counter, shadow register, leading-digit detect, and output registers.

## Test plan
Bench uses SCAN_DIV=4, BLANK_CYC=1.
1. Reset: Rst high 2 cycles → which=0, seg=FF; after release, 1 cycle FF, then BF on every digit until the first frame boundary.
2. data={32'h0123ABCD,1'b1} held for 2 frames → in the second frame digits 0..7 show A1,C6,83,88,B0,A4,F9,C0, each preceded by 1 FF cycle.
3. Change data from 32'h11111111 to 32'h22222222 while which=3 → digits 4..7 of that frame still show F9; next frame shows A4 on all digits.
4. data valid bit 0 with value 32'hFFFFFFFF → after the boundary all digits show BF, never 8E.
5. With HEX_SCAN_LEAD_ZERO_BLANK_EN: 32'h000000A5 valid → digit0=92, digit1=88, digits 2..7=FF; value 0 → digit0=C0, others FF.
6. Rst pulsed while which=5 and pcnt=2 → next cycle which=0, pcnt=0, seg=FF; display reverts to dashes until the next boundary.
